window_streamer: RTL and testbench

Parametrised successor to the team's fixed 80×80 / 16×16 window loader. Fills an on-chip square pixel region from word-wide memory reads, then streams every K×K sub-window at a configurable stride to the downstream matcher. Both sides use valid/ready-style handshakes in place of fixed wait cycles. Abort, window-position outputs and an optional stall counter are added. Sits between the frame-memory read port and the template-match datapath.

---
 rtl/window_streamer_if.sv | 33 +++
 rtl/window_streamer.sv | 191 +++++++++++++++++++
 tb/tb_window_streamer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/window_streamer_if.sv
// Frame-memory read port and window output bundle for window_streamer.
// master = streamer side, slave = memory/consumer side.
interface window_streamer_if #(
    parameter int unsigned REGION = 80,
    parameter int unsigned WIN    = 16,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned WORD_W = 32
);
    localparam int unsigned PPW  = WORD_W / PIX_W;
    localparam int unsigned COLS = REGION / PPW;
    localparam int unsigned AW   = (REGION > 1) ? $clog2(REGION) : 1;
    localparam int unsigned CW   = (COLS > 1) ? $clog2(COLS) : 1;

    logic [AW-1:0]              rd_row;
    logic [CW-1:0]              rd_col;
    logic [WORD_W-1:0]          rd_data;
    logic                       rd_valid;
    logic [WIN*WIN*PIX_W-1:0]   window_data;
    logic                       window_valid;
    logic                       window_ready;
    logic [AW-1:0]              win_row;
    logic [AW-1:0]              win_col;

    modport master (
        output rd_row, rd_col, window_data, window_valid, win_row, win_col,
        input  rd_data, rd_valid, window_ready
    );

    modport slave (
        input  rd_row, rd_col, window_data, window_valid, win_row, win_col,
        output rd_data, rd_valid, window_ready
    );
endinterface

// File: rtl/window_streamer.sv
// Loads a REGION x REGION pixel buffer from word reads, then streams every WIN x WIN window
// at STRIDE. Optional stall counter enabled by defining WINDOW_STREAMER_STALL_EN.
module window_streamer #(
    parameter int unsigned REGION = 80,
    parameter int unsigned WIN    = 16,
    parameter int unsigned STRIDE = 1,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned WORD_W = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic abort,
    output logic ack,
    output logic busy,
    output logic done,
    window_streamer_if.master bus
`ifdef WINDOW_STREAMER_STALL_EN
    ,
    output logic [31:0] stall_cnt
`endif
);
    localparam int unsigned PPW      = WORD_W / PIX_W;
    localparam int unsigned COLS     = REGION / PPW;
    localparam int unsigned AW       = (REGION > 1) ? $clog2(REGION) : 1;
    localparam int unsigned CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned LAST_POS = REGION - WIN;

    generate
        if ((WORD_W % PIX_W) != 0 || PPW == 0 || (REGION % PPW) != 0 || WIN > REGION ||
            WIN == 0 || ((REGION - WIN) % STRIDE) != 0) begin : g_param_check
            $error("window_streamer: illegal REGION/WIN/STRIDE/PIX_W/WORD_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {StIdle, StFill, StStream} state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] rd_row_q, rd_row_d;
    logic [CW-1:0] rd_col_q, rd_col_d;
    logic [AW-1:0] win_row_q, win_row_d;
    logic [AW-1:0] win_col_q, win_col_d;
    logic          done_q, done_d;
    logic          mem_we;

    // Pixel buffer, deliberately not reset.
    logic [PIX_W-1:0] pix_mem [REGION][REGION];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and address/position update; abort wins over any handshake.
    always_comb begin
        state_d   = state_q;
        rd_row_d  = rd_row_q;
        rd_col_d  = rd_col_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        done_d    = 1'b0;
        mem_we    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d  = StFill;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end
            end
            StFill: begin
                if (abort) begin
                    state_d  = StIdle;
                    rd_row_d = '0;
                    rd_col_d = '0;
                end else if (bus.rd_valid) begin
                    mem_we = 1'b1;
                    if (rd_col_q == CW'(COLS - 1)) begin
                        rd_col_d = '0;
                        if (rd_row_q == AW'(REGION - 1)) begin
                            state_d   = StStream;
                            rd_row_d  = '0;
                            win_row_d = '0;
                            win_col_d = '0;
                        end else begin
                            rd_row_d = rd_row_q + 1'b1;
                        end
                    end else begin
                        rd_col_d = rd_col_q + 1'b1;
                    end
                end
            end
            StStream: begin
                if (abort) begin
                    state_d   = StIdle;
                    win_row_d = '0;
                    win_col_d = '0;
                end else if (bus.window_ready) begin
                    if (win_col_q == AW'(LAST_POS)) begin
                        win_col_d = '0;
                        if (win_row_q == AW'(LAST_POS)) begin
                            state_d   = StIdle;
                            win_row_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            win_row_d = win_row_q + AW'(STRIDE);
                        end
                    end else begin
                        win_col_d = win_col_q + AW'(STRIDE);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        ack              = (state_q == StIdle) && en;
        busy             = (state_q != StIdle);
        bus.window_valid = (state_q == StStream);
        done             = done_q;
        bus.rd_row       = rd_row_q;
        bus.rd_col       = rd_col_q;
        bus.win_row      = win_row_q;
        bus.win_col      = win_col_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_row_q  <= '0;
            rd_col_q  <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            done_q    <= 1'b0;
        end else begin
            rd_row_q  <= rd_row_d;
            rd_col_q  <= rd_col_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            done_q    <= done_d;
        end
    end

    // Leftmost pixel of a word sits in its MSBs.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned k = 0; k < PPW; k++) begin
                pix_mem[rd_row_q][AW'(int'(rd_col_q) * PPW + k)] <=
                    bus.rd_data[WORD_W - 1 - k * PIX_W -: PIX_W];
            end
        end
    end

    always_comb begin
        bus.window_data = '0;
        if (state_q == StStream) begin
            for (int unsigned i = 0; i < WIN; i++) begin
                for (int unsigned j = 0; j < WIN; j++) begin
                    bus.window_data[(i * WIN + j) * PIX_W +: PIX_W] =
                        pix_mem[win_row_q + AW'(i)][win_col_q + AW'(j)];
                end
            end
        end
    end

`ifdef WINDOW_STREAMER_STALL_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (ack) begin
            stall_cnt_d = '0;
        end else if (state_q == StStream && !bus.window_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_window_streamer.sv
// Self-checking bench for window_streamer: directed job sequence with randomized handshakes,
// checked against an array-based model of the region and the expected window order.
module tb_window_streamer;
    localparam int unsigned REGION = 80;
    localparam int unsigned WIN    = 16;
    localparam int unsigned PIX_W  = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned PPW    = WORD_W / PIX_W;
    localparam int unsigned COLS   = REGION / PPW;
    localparam int unsigned AW     = 7;
    localparam int unsigned NPOS   = REGION - WIN + 1;
    localparam int unsigned NWIN   = NPOS * NPOS;
    localparam int unsigned WD     = WIN * WIN * PIX_W;

    logic clk = 1'b0;
    logic rst;
    logic en, abort, ack, busy, done;
    logic en16, abort16, ack16, busy16, done16;
`ifdef WINDOW_STREAMER_STALL_EN
    logic [31:0] stall_cnt, stall_cnt16;
`endif

    int vectors     = 0;
    int miscompares = 0;
    logic [PIX_W-1:0] region [REGION][REGION];

    always #5 clk = ~clk;

    window_streamer_if #(.REGION(REGION), .WIN(WIN), .PIX_W(PIX_W), .WORD_W(WORD_W)) bus ();
    window_streamer_if #(.REGION(REGION), .WIN(WIN), .PIX_W(PIX_W), .WORD_W(WORD_W)) bus16 ();

    window_streamer #(
        .REGION(REGION), .WIN(WIN), .STRIDE(1), .PIX_W(PIX_W), .WORD_W(WORD_W)
    ) u_dut (
        .clk(clk), .rst(rst), .en(en), .abort(abort), .ack(ack), .busy(busy), .done(done),
        .bus(bus)
`ifdef WINDOW_STREAMER_STALL_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    window_streamer #(
        .REGION(REGION), .WIN(WIN), .STRIDE(16), .PIX_W(PIX_W), .WORD_W(WORD_W)
    ) u_dut16 (
        .clk(clk), .rst(rst), .en(en16), .abort(abort16), .ack(ack16), .busy(busy16),
        .done(done16), .bus(bus16)
`ifdef WINDOW_STREAMER_STALL_EN
        , .stall_cnt(stall_cnt16)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [WD-1:0] obs, input logic [WD-1:0] exp);
        int p;
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            p = 0;
            for (int i = WIN * WIN - 1; i >= 0; i--) begin
                if (obs[i * PIX_W +: PIX_W] !== exp[i * PIX_W +: PIX_W]) p = i;
            end
            $error("FAIL %s: pixel %0d got %0h expected %0h", tag, p,
                   obs[p * PIX_W +: PIX_W], exp[p * PIX_W +: PIX_W]);
        end
    endtask

    function automatic logic [WORD_W-1:0] word_of(int r, int wc);
        logic [WORD_W-1:0] w;
        for (int k = 0; k < PPW; k++) w[WORD_W - 1 - k * PIX_W -: PIX_W] =
            region[AW'(r)][AW'(wc * PPW + k)];
        return w;
    endfunction

    function automatic logic [WD-1:0] exp_window(int r0, int c0);
        logic [WD-1:0] w;
        for (int i = 0; i < WIN; i++)
            for (int j = 0; j < WIN; j++)
                w[(i * WIN + j) * PIX_W +: PIX_W] = region[AW'(r0 + i)][AW'(c0 + j)];
        return w;
    endfunction

    task automatic fill_region(input bit random_fill);
        for (int r = 0; r < REGION; r++)
            for (int c = 0; c < REGION; c++)
                region[r][c] = random_fill ? PIX_W'($urandom) : PIX_W'((r * 80 + c) % 256);
    endtask

    // One job on the stride-1 DUT; negative abort/rst/stall indices disable that event.
    task automatic run_job(input int rv_pct, input int wr_pct, input int abort_word,
                           input int abort_win, input int rst_win, input int stall_at);
        int words, k, cyc, stalls, stall_left, pr, pc;
        bit stall_done;
        en = 1'b1;
        #1;
        chk("ack", 64'(ack), 64'd1);
        chk("busy_idle", 64'(busy), 64'd0);
        tick();
        en = 1'b0;
`ifdef WINDOW_STREAMER_STALL_EN
        chk("stall_clr", 64'(stall_cnt), 64'd0);
`endif
        chk("busy_fill", 64'(busy), 64'd1);
        chk_win("data_fill", bus.window_data, '0);

        words = 0;
        cyc   = 0;
        while (words < REGION * COLS) begin
            chk("rd_row", 64'(bus.rd_row), 64'(words / COLS));
            chk("rd_col", 64'(bus.rd_col), 64'(words % COLS));
            bus.rd_valid = ($urandom_range(99) < rv_pct);
            bus.rd_data  = bus.rd_valid ? word_of(words / COLS, words % COLS) : WORD_W'($urandom);
            if (words == abort_word && bus.rd_valid) begin
                abort = 1'b1;
                tick();
                abort        = 1'b0;
                bus.rd_valid = 1'b0;
                chk("fill_abort_busy", 64'(busy), 64'd0);
                chk("fill_abort_done", 64'(done), 64'd0);
                chk("fill_abort_vld", 64'(bus.window_valid), 64'd0);
                return;
            end
            tick();
            cyc++;
            if (bus.rd_valid) words++;
            if (cyc > 20000) begin
                chk("fill_timeout", 64'(words), 64'(REGION * COLS));
                bus.rd_valid = 1'b0;
                return;
            end
        end
        bus.rd_valid = 1'b0;
        if (rv_pct >= 100) chk("fill_cycles", 64'(cyc), 64'(REGION * COLS));

        k          = 0;
        cyc        = 0;
        stalls     = 0;
        stall_left = 0;
        stall_done = 1'b0;
        while (k < NWIN) begin
            pr = k / NPOS;
            pc = k % NPOS;
            chk("win_valid", 64'(bus.window_valid), 64'd1);
            chk("win_row", 64'(bus.win_row), 64'(pr));
            chk("win_col", 64'(bus.win_col), 64'(pc));
            chk("done_low", 64'(done), 64'd0);
            chk_win("win_data", bus.window_data, exp_window(pr, pc));
            if (k == abort_win || k == rst_win) begin
                bus.window_ready = 1'b1;
                if (k == abort_win) abort = 1'b1;
                else rst = 1'b1;
                tick();
                abort            = 1'b0;
                rst              = 1'b0;
                bus.window_ready = 1'b0;
                chk("cut_busy", 64'(busy), 64'd0);
                chk("cut_done", 64'(done), 64'd0);
                chk("cut_vld", 64'(bus.window_valid), 64'd0);
                chk_win("cut_data", bus.window_data, '0);
                if (k == rst_win) begin
                    chk("rst_ack", 64'(ack), 64'd0);
                    chk("rst_rd_row", 64'(bus.rd_row), 64'd0);
                    chk("rst_rd_col", 64'(bus.rd_col), 64'd0);
                    chk("rst_win_row", 64'(bus.win_row), 64'd0);
                    chk("rst_win_col", 64'(bus.win_col), 64'd0);
`ifdef WINDOW_STREAMER_STALL_EN
                    chk("rst_stall", 64'(stall_cnt), 64'd0);
`endif
                end
                return;
            end
            if (k == stall_at && !stall_done) begin
                stall_left = 7;
                stall_done = 1'b1;
            end
            if (stall_left > 0) begin
                bus.window_ready = 1'b0;
                stall_left--;
            end else begin
                bus.window_ready = ($urandom_range(99) < wr_pct);
            end
            if (!bus.window_ready) stalls++;
            tick();
            cyc++;
            if (bus.window_ready) k++;
            if (cyc > 40000) begin
                chk("stream_timeout", 64'(k), 64'(NWIN));
                bus.window_ready = 1'b0;
                return;
            end
        end
        bus.window_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("vld_at_done", 64'(bus.window_valid), 64'd0);
        chk_win("data_at_done", bus.window_data, '0);
        if (wr_pct >= 100 && stall_at < 0) chk("stream_cycles", 64'(cyc), 64'(NWIN));
`ifdef WINDOW_STREAMER_STALL_EN
        chk("stall_at_done", 64'(stall_cnt), 64'(stalls));
`endif
    endtask

    task automatic run_s16();
        int words, k, cyc, last_r, last_c;
        en16 = 1'b1;
        tick();
        en16 = 1'b0;
        bus16.rd_valid = 1'b1;
        for (words = 0; words < REGION * COLS; words++) begin
            bus16.rd_data = word_of(words / COLS, words % COLS);
            tick();
        end
        bus16.rd_valid     = 1'b0;
        bus16.window_ready = 1'b1;
        k      = 0;
        cyc    = 0;
        last_r = -1;
        last_c = -1;
        while (bus16.window_valid && cyc < 100) begin
            chk("s16_row", 64'(bus16.win_row), 64'((k / 5) * 16));
            chk("s16_col", 64'(bus16.win_col), 64'((k % 5) * 16));
            chk_win("s16_data", bus16.window_data, exp_window((k / 5) * 16, (k % 5) * 16));
            last_r = int'(bus16.win_row);
            last_c = int'(bus16.win_col);
            tick();
            k++;
            cyc++;
        end
        bus16.window_ready = 1'b0;
        chk("s16_count", 64'(k), 64'd25);
        chk("s16_last_row", 64'(last_r), 64'd64);
        chk("s16_last_col", 64'(last_c), 64'd64);
        chk("s16_done", 64'(done16), 64'd1);
    endtask

    initial begin
        rst                = 1'b1;
        en                 = 1'b0;
        abort              = 1'b0;
        en16               = 1'b0;
        abort16            = 1'b0;
        bus.rd_valid       = 1'b0;
        bus.rd_data        = '0;
        bus.window_ready   = 1'b0;
        bus16.rd_valid     = 1'b0;
        bus16.rd_data      = '0;
        bus16.window_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_ack", 64'(ack), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_vld", 64'(bus.window_valid), 64'd0);
        chk("reset_rd_row", 64'(bus.rd_row), 64'd0);
        chk("reset_rd_col", 64'(bus.rd_col), 64'd0);
        chk("reset_win_row", 64'(bus.win_row), 64'd0);
        chk("reset_win_col", 64'(bus.win_col), 64'd0);
        chk_win("reset_data", bus.window_data, '0);
`ifdef WINDOW_STREAMER_STALL_EN
        chk("reset_stall", 64'(stall_cnt), 64'd0);
`endif

        // Full-rate job on the ramp pattern, then confirm done is a single pulse.
        fill_region(1'b0);
        run_job(100, 100, -1, -1, -1, -1);
        tick();
        chk("done_single", 64'(done), 64'd0);

        // Random handshakes, same pattern; next job starts in the done cycle with a 7-cycle stall.
        run_job(50, 50, -1, -1, -1, -1);
        fill_region(1'b1);
        run_job(100, 100, -1, -1, -1, 20);
        tick();

        // Abort on the 100th word, then during STREAM at window 10, then a clean job.
        run_job(100, 100, 99, -1, -1, -1);
        tick();
        chk("idle_after_abort", 64'(busy), 64'd0);
        run_job(100, 100, -1, 10, -1, -1);
        tick();
        chk("no_done_after_abort", 64'(done), 64'd0);
        fill_region(1'b1);
        run_job(100, 100, -1, -1, -1, -1);
        tick();

        // Reset mid-STREAM, then a clean restart.
        run_job(100, 100, -1, -1, 500, -1);
        tick();
        fill_region(1'b1);
        run_job(100, 100, -1, -1, -1, -1);
        tick();

        run_s16();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
